la_capture_fifo: RTL

User-area block in user_project_wrapper that buffers words pushed by management firmware over the logic analyzer (LA) and returns them to the SoC for readback. Firmware reads head data and status on la_data_out; a 16-bit status code is driven on mprj_io[31:16] for the LA-test benches to watch as checkbits. It sits directly downstream of the LA-driving firmware and upstream of the testbench checkbit monitor.

---
 rtl/la_capture_pkg.sv | 19 +
 rtl/la_sync_fifo.sv | 99 +++++++++
 rtl/la_capture_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/la_capture_pkg.sv
// Shared constants for the LA capture FIFO: LA bit map, IO status field and
// the packing helper for the 16-bit checkbit word.
package la_capture_pkg;

    localparam int PUSH_BIT   = 64;
    localparam int POP_BIT    = 65;
    localparam int CLR_BIT    = 66;
    localparam int STAT_BASE  = 32;

    localparam logic [7:0] STATUS_TAG = 8'hCA;
    localparam int IO_STAT_LO = 16;
    localparam int IO_STAT_HI = 31;

    function automatic logic [15:0] io_status(input logic ovf, input logic udf,
                                              input logic [3:0] cnt);
        return {STATUS_TAG, 2'b00, ovf, udf, cnt};
    endfunction

endpackage

// File: rtl/la_sync_fifo.sv
// Single-clock FIFO with sticky overflow/underflow flags and a registered
// occupancy-threshold level. Clear outranks push/pop in the same cycle.
module la_sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_ovf,
    output logic                       o_udf,
    output logic                       o_thr
);
    import la_capture_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             r_thr;

    logic [CW-1:0]    w_count_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_ovf_set;
    logic             w_udf_set;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == CW'(DEPTH));
        w_do_pop  = i_pop & ~w_empty;
        w_do_push = i_push & (~w_full | i_pop);
        w_ovf_set = i_push & w_full & ~i_pop;
        w_udf_set = i_pop & w_empty;

        w_count_nxt = r_count;
        if (i_clr)
            w_count_nxt = '0;
        else if (w_do_push & ~w_do_pop)
            w_count_nxt = r_count + CW'(1);
        else if (~w_do_push & w_do_pop)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_thr    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_thr   <= (w_count_nxt >= CW'(THRESH));
            if (i_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_ovf_set) r_ovf    <= 1'b1;
                if (w_udf_set) r_udf    <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clr && w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;
    assign o_thr   = r_thr;

endmodule

// File: rtl/la_capture_fifo.sv
// LA-driven capture FIFO: gates firmware strobes, edge-detects them, and packs
// FIFO head/status onto la_data_out, the mprj_io checkbit field and irq.
module la_capture_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);
    import la_capture_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] w_wdata;
    logic             w_push_s, w_pop_s, w_clr_s;
    logic             r_push_q, r_pop_q, r_clr_q;
    logic             w_push_ev, w_pop_ev, w_clr_ev;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_empty, w_full, w_ovf, w_udf, w_thr;
    logic [31:0]      w_head32;
    logic [3:0]       w_count4;
    logic             w_unused;

    // Strobe protocol: firmware raises a level on PUSH/POP/CLR (with its oenb
    // bit low); each 0->1 transition is one command, acted on at that edge.
    assign w_wdata  = la_data_in[WIDTH-1:0] & ~la_oenb[WIDTH-1:0];
    assign w_push_s = la_data_in[PUSH_BIT] & ~la_oenb[PUSH_BIT];
    assign w_pop_s  = la_data_in[POP_BIT]  & ~la_oenb[POP_BIT];
    assign w_clr_s  = la_data_in[CLR_BIT]  & ~la_oenb[CLR_BIT];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_push_q <= 1'b0;
            r_pop_q  <= 1'b0;
            r_clr_q  <= 1'b0;
        end else begin
            r_push_q <= w_push_s;
            r_pop_q  <= w_pop_s;
            r_clr_q  <= w_clr_s;
        end
    end

    assign w_push_ev = w_push_s & ~r_push_q;
    assign w_pop_ev  = w_pop_s  & ~r_pop_q;
    assign w_clr_ev  = w_clr_s  & ~r_clr_q;

    la_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .THRESH(THRESH)
    ) u_fifo (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_clr  (w_clr_ev),
        .i_push (w_push_ev),
        .i_pop  (w_pop_ev),
        .i_wdata(w_wdata),
        .o_head (w_head),
        .o_count(w_count),
        .o_empty(w_empty),
        .o_full (w_full),
        .o_ovf  (w_ovf),
        .o_udf  (w_udf),
        .o_thr  (w_thr)
    );

    always_comb begin
        w_head32              = '0;
        w_head32[WIDTH-1:0]   = w_head;
        w_count4              = '0;
        w_count4[CW-1:0]      = w_count;

        la_data_out                      = '0;
        la_data_out[31:0]                = w_head32;
        la_data_out[STAT_BASE +: 4]      = w_count4;
        la_data_out[STAT_BASE + 4]       = w_empty;
        la_data_out[STAT_BASE + 5]       = w_full;
        la_data_out[STAT_BASE + 6]       = w_ovf;
        la_data_out[STAT_BASE + 7]       = w_udf;

        io_out                           = '0;
        io_out[IO_STAT_HI:IO_STAT_LO]    = io_status(w_ovf, w_udf, w_count4);
        io_oeb                           = '1;
        io_oeb[IO_STAT_HI:IO_STAT_LO]    = '0;
    end

    assign irq = {w_udf, w_ovf, w_thr};

    assign w_unused = ^{la_data_in[127:CLR_BIT+1], la_data_in[PUSH_BIT-1:WIDTH],
                        la_oenb[127:CLR_BIT+1], la_oenb[PUSH_BIT-1:WIDTH]};

endmodule
